lif_neuron_layer: RTL



---
 rtl/snn_neuron_pkg.sv | 26 ++
 rtl/lif_update_unit.sv | 51 +++++
 rtl/lif_neuron_layer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/snn_neuron_pkg.sv
// Shared types and helpers for the leaky integrate-and-fire neuron layer.
// Holds the layer FSM encoding, the default membrane width and a saturating adder.
package snn_neuron_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    OUTPUT = 2'd2
  } lif_state_e;

  localparam int unsigned V_W_DEFAULT = 16;

  typedef logic [V_W_DEFAULT-1:0] membrane_t;

  // Returns min(a + b, 2^width - 1); valid for width <= 32 with a, b already below 2^width.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned width);
    logic [32:0] sum;
    logic [32:0] max_val;
    sum     = {1'b0, a} + {1'b0, b};
    max_val = (33'd1 << width) - 33'd1;
    return (sum > max_val) ? max_val[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/lif_update_unit.sv
// Combinational single-neuron datapath: leak, clamped integration, threshold,
// reset-on-fire and refractory countdown for one membrane per evaluation.
module lif_update_unit
  import snn_neuron_pkg::*;
#(
  parameter int SUM_W        = 32,
  parameter int V_W          = V_W_DEFAULT,
  parameter int R_W          = 2,
  parameter int REFRAC_STEPS = 2
) (
  input  logic [V_W-1:0]   v,
  input  logic [R_W-1:0]   r,
  input  logic [SUM_W-1:0] sum,
  input  logic [V_W-1:0]   threshold,
  input  logic [3:0]       leak_shift,
  output logic [V_W-1:0]   v_next,
  output logic [R_W-1:0]   r_next,
  output logic             fire
);

  localparam int CW = (SUM_W > V_W) ? SUM_W : V_W;
  localparam logic [V_W-1:0] V_MAX = '1;

  logic [V_W-1:0] leak;
  logic [V_W-1:0] in_clamped;
  logic [V_W-1:0] v_int;
  logic [CW-1:0]  sum_ext;

  // NOTE: every output gets a default before any branch so no latch is inferred.
  always_comb begin
    v_next = '0;
    r_next = '0;
    fire   = 1'b0;

    // Shift of zero removes the whole membrane; shifts past the width leak nothing.
    leak       = (32'(leak_shift) >= V_W) ? '0 : (v >> leak_shift);
    sum_ext    = CW'(sum);
    in_clamped = (sum_ext > CW'(V_MAX)) ? V_MAX : sum_ext[V_W-1:0];
    v_int      = V_W'(sat_add(32'(v - leak), 32'(in_clamped), V_W));

    if (r != '0) begin
      r_next = r - R_W'(1);
    end else if (v_int >= threshold) begin
      fire   = 1'b1;
      r_next = R_W'(REFRAC_STEPS);
    end else begin
      v_next = v_int;
    end
  end

endmodule

// File: rtl/lif_neuron_layer.sv
// Layer of COLS LIF neurons sharing one update unit, one neuron per cycle.
// Accepts a weighted-sum vector per timestep and returns the spike vector.
module lif_neuron_layer
  import snn_neuron_pkg::*;
#(
  parameter int COLS         = 10,
  parameter int SUM_W        = 32,
  parameter int V_W          = V_W_DEFAULT,
  parameter int REFRAC_STEPS = 2,
  parameter int IDX_W        = $clog2(COLS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_valid,
  output logic             step_ready,
  input  logic [SUM_W-1:0] weighted_sum [COLS],
  input  logic [V_W-1:0]   cfg_threshold,
  input  logic [3:0]       cfg_leak_shift,
  input  logic             clear_state,
  output logic             spike_valid,
  input  logic             spike_ready,
  output logic [COLS-1:0]  spikes,
  output logic             busy
);

  localparam int R_W = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COLS - 1);

  lif_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [V_W-1:0]   v_q [COLS];
  logic [V_W-1:0]   v_d [COLS];
  logic [R_W-1:0]   r_q [COLS];
  logic [R_W-1:0]   r_d [COLS];
  logic [COLS-1:0]  spikes_q, spikes_d;
  logic [SUM_W-1:0] sum_snap_q [COLS];
  logic [SUM_W-1:0] sum_snap_d [COLS];
  logic [V_W-1:0]   thr_q, thr_d;
  logic [3:0]       shift_q, shift_d;

  logic [V_W-1:0]   upd_v_next;
  logic [R_W-1:0]   upd_r_next;
  logic             upd_fire;

  lif_update_unit #(
    .SUM_W       (SUM_W),
    .V_W         (V_W),
    .R_W         (R_W),
    .REFRAC_STEPS(REFRAC_STEPS)
  ) u_update (
    .v         (v_q[idx_q]),
    .r         (r_q[idx_q]),
    .sum       (sum_snap_q[idx_q]),
    .threshold (thr_q),
    .leak_shift(shift_q),
    .v_next    (upd_v_next),
    .r_next    (upd_r_next),
    .fire      (upd_fire)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    v_d        = v_q;
    r_d        = r_q;
    spikes_d   = spikes_q;
    sum_snap_d = sum_snap_q;
    thr_d      = thr_q;
    shift_d    = shift_q;

    case (state_q)
      IDLE: begin
        // A clear owns the cycle; the step handshake waits until it drops.
        if (clear_state) begin
          for (int i = 0; i < COLS; i++) begin
            v_d[i] = '0;
            r_d[i] = '0;
          end
        end else if (step_valid) begin
          sum_snap_d = weighted_sum;
          thr_d      = cfg_threshold;
          shift_d    = cfg_leak_shift;
          idx_d      = '0;
          state_d    = UPDATE;
        end
      end
      UPDATE: begin
        v_d[idx_q]      = upd_v_next;
        r_d[idx_q]      = upd_r_next;
        spikes_d[idx_q] = upd_fire;
        if (idx_q == LAST_IDX) begin
          state_d = OUTPUT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      OUTPUT: begin
        if (spike_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      spikes_q <= '0;
      thr_q    <= '0;
      shift_q  <= '0;
      // NOTE: membranes, refractory counters and snapshots are flop arrays, not RAM, so they take the reset.
      for (int i = 0; i < COLS; i++) begin
        v_q[i]        <= '0;
        r_q[i]        <= '0;
        sum_snap_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      spikes_q   <= spikes_d;
      thr_q      <= thr_d;
      shift_q    <= shift_d;
      v_q        <= v_d;
      r_q        <= r_d;
      sum_snap_q <= sum_snap_d;
    end
  end

  assign step_ready  = (state_q == IDLE) && !clear_state;
  assign spike_valid = (state_q == OUTPUT);
  assign busy        = (state_q != IDLE);
  assign spikes      = spikes_q;

endmodule
